// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package hazard_pkg;

    // EX-stage operand source select
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } forward_sel_e;

    // Multi-cycle operation sequencer state
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // result_src encoding that marks a load in EX
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // True when a later stage writes a non-x0 register that matches rs
    function automatic logic rd_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if;
    logic [4:0] rs1_addr_d_i;
    logic [4:0] rs2_addr_d_i;
    logic [4:0] rs1_addr_e_i;
    logic [4:0] rs2_addr_e_i;
    logic [4:0] rd_addr_e_i;
    logic       op_a_is_rs1_e_i;
    logic       alu_src_e_i;
    logic [1:0] result_src_e_i;
    logic [4:0] rd_addr_m_i;
    logic       reg_write_m_i;
    logic [4:0] rd_addr_w_i;
    logic       reg_write_w_i;
    logic       pc_src_e_i;
    logic       mc_op_e_i;
    logic       mc_done_i;

    logic [1:0] forward_a_e_o;
    logic [1:0] forward_b_e_o;
    logic       stall_f_o;
    logic       stall_d_o;
    logic       stall_e_o;
    logic       flush_d_o;
    logic       flush_e_o;
    logic       flush_m_o;
    logic       mc_start_o;
    logic       mc_busy_o;
    logic       mc_error_o;

    modport master (
        output rs1_addr_d_i, rs2_addr_d_i, rs1_addr_e_i, rs2_addr_e_i, rd_addr_e_i,
               op_a_is_rs1_e_i, alu_src_e_i, result_src_e_i,
               rd_addr_m_i, reg_write_m_i, rd_addr_w_i, reg_write_w_i,
               pc_src_e_i, mc_op_e_i, mc_done_i,
        input  forward_a_e_o, forward_b_e_o, stall_f_o, stall_d_o, stall_e_o,
               flush_d_o, flush_e_o, flush_m_o, mc_start_o, mc_busy_o, mc_error_o
    );

    modport slave (
        input  rs1_addr_d_i, rs2_addr_d_i, rs1_addr_e_i, rs2_addr_e_i, rd_addr_e_i,
               op_a_is_rs1_e_i, alu_src_e_i, result_src_e_i,
               rd_addr_m_i, reg_write_m_i, rd_addr_w_i, reg_write_w_i,
               pc_src_e_i, mc_op_e_i, mc_done_i,
        output forward_a_e_o, forward_b_e_o, stall_f_o, stall_d_o, stall_e_o,
               flush_d_o, flush_e_o, flush_m_o, mc_start_o, mc_busy_o, mc_error_o
    );
endinterface

// File: rtl/forward_select.sv
// Operand forwarding select for one EX source register; MEM beats WB.
module forward_select
    import hazard_pkg::*;
(
    input  logic [4:0]   i_rs_addr,
    input  logic [4:0]   i_rd_addr_m,
    input  logic         i_reg_write_m,
    input  logic [4:0]   i_rd_addr_w,
    input  logic         i_reg_write_w,
    input  logic         i_en,
    output forward_sel_e o_sel
);

    // Pick the youngest in-flight producer of the source register
    always_comb begin
        o_sel = FWD_NONE;
        if (i_en) begin
            if (rd_hit(i_rd_addr_m, i_reg_write_m, i_rs_addr)) begin
                o_sel = FWD_MEM;
            end else if (rd_hit(i_rd_addr_w, i_reg_write_w, i_rs_addr)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use stall, redirect flush,
// and sequencing of multi-cycle EX operations with a timeout guard.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave bus
);

    localparam int unsigned          CNT_W   = $clog2(MC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MC_TIMEOUT);

    mc_state_e        r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_mc_busy;
    logic             r_mc_error;

    forward_sel_e w_fwd_a;
    forward_sel_e w_fwd_b;
    logic         w_lw_stall;
    logic         w_mc_enter;
    logic         w_mc_start_idle;
    logic         w_busy_hold;

    forward_select u_fwd_a (
        .i_rs_addr     (bus.rs1_addr_e_i),
        .i_rd_addr_m   (bus.rd_addr_m_i),
        .i_reg_write_m (bus.reg_write_m_i),
        .i_rd_addr_w   (bus.rd_addr_w_i),
        .i_reg_write_w (bus.reg_write_w_i),
        .i_en          (bus.op_a_is_rs1_e_i),
        .o_sel         (w_fwd_a)
    );

    forward_select u_fwd_b (
        .i_rs_addr     (bus.rs2_addr_e_i),
        .i_rd_addr_m   (bus.rd_addr_m_i),
        .i_reg_write_m (bus.reg_write_m_i),
        .i_rd_addr_w   (bus.rd_addr_w_i),
        .i_reg_write_w (bus.reg_write_w_i),
        .i_en          (!bus.alu_src_e_i),
        .o_sel         (w_fwd_b)
    );

    // Hazard conditions decoded from the current inputs and FSM state
    always_comb begin
        w_lw_stall      = (bus.result_src_e_i == RESULT_SRC_LOAD) &&
                          (bus.rd_addr_e_i != '0) &&
                          ((bus.rd_addr_e_i == bus.rs1_addr_d_i) ||
                           (bus.rd_addr_e_i == bus.rs2_addr_d_i));
        w_mc_enter      = (r_state == IDLE) && bus.mc_op_e_i && !bus.pc_src_e_i && !bus.mc_done_i;
        w_mc_start_idle = (r_state == IDLE) && bus.mc_op_e_i && (bus.mc_done_i || !bus.pc_src_e_i);
        w_busy_hold     = (r_state == BUSY) && !bus.mc_done_i && (r_count < CNT_MAX);
    end

    // Multi-cycle sequencer: state, cycle counter, busy flag and sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_mc_busy  <= 1'b0;
            r_mc_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mc_enter) begin
                        r_state   <= BUSY;
                        r_count   <= CNT_W'(1);
                        r_mc_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.mc_done_i) begin
                        r_state   <= IDLE;
                        r_count   <= '0;
                        r_mc_busy <= 1'b0;
                    end else if (r_count >= CNT_MAX) begin
                        r_state    <= IDLE;
                        r_count    <= '0;
                        r_mc_busy  <= 1'b0;
                        r_mc_error <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_count   <= '0;
                    r_mc_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stall/flush/forward enables; multi-cycle hold outranks load-use, redirect outranks load-use
    always_comb begin
        bus.forward_a_e_o = FWD_NONE;
        bus.forward_b_e_o = FWD_NONE;
        bus.stall_f_o     = 1'b0;
        bus.stall_d_o     = 1'b0;
        bus.stall_e_o     = 1'b0;
        bus.flush_d_o     = 1'b0;
        bus.flush_e_o     = 1'b0;
        bus.flush_m_o     = 1'b0;
        bus.mc_start_o    = 1'b0;
        if (rst_n) begin
            bus.forward_a_e_o = w_fwd_a;
            bus.forward_b_e_o = w_fwd_b;
            if (r_state == BUSY) begin
                bus.stall_f_o = w_busy_hold;
                bus.stall_d_o = w_busy_hold;
                bus.stall_e_o = w_busy_hold;
                bus.flush_m_o = w_busy_hold;
            end else if (w_mc_enter) begin
                bus.mc_start_o = 1'b1;
                bus.stall_f_o  = 1'b1;
                bus.stall_d_o  = 1'b1;
                bus.stall_e_o  = 1'b1;
                bus.flush_m_o  = 1'b1;
            end else begin
                bus.mc_start_o = w_mc_start_idle;
                bus.stall_f_o  = w_lw_stall && !bus.pc_src_e_i;
                bus.stall_d_o  = w_lw_stall && !bus.pc_src_e_i;
                bus.flush_e_o  = w_lw_stall || bus.pc_src_e_i;
                bus.flush_d_o  = bus.pc_src_e_i;
            end
        end
    end

    assign bus.mc_busy_o  = r_mc_busy;
    assign bus.mc_error_o = r_mc_error;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; output vector order is
// {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, start, busy, error}.
module tb_hazard_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_unit_if bus ();

    hazard_unit #(.MC_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clr();
        bus.rs1_addr_d_i    = '0;
        bus.rs2_addr_d_i    = '0;
        bus.rs1_addr_e_i    = '0;
        bus.rs2_addr_e_i    = '0;
        bus.rd_addr_e_i     = '0;
        bus.op_a_is_rs1_e_i = 1'b1;
        bus.alu_src_e_i     = 1'b0;
        bus.result_src_e_i  = '0;
        bus.rd_addr_m_i     = '0;
        bus.reg_write_m_i   = 1'b0;
        bus.rd_addr_w_i     = '0;
        bus.reg_write_w_i   = 1'b0;
        bus.pc_src_e_i      = 1'b0;
        bus.mc_op_e_i       = 1'b0;
        bus.mc_done_i       = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        #1;
        obs = {bus.forward_a_e_o, bus.forward_b_e_o, bus.stall_f_o, bus.stall_d_o, bus.stall_e_o,
               bus.flush_d_o, bus.flush_e_o, bus.flush_m_o, bus.mc_start_o, bus.mc_busy_o, bus.mc_error_o};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr();

        // Reset: inputs that would otherwise fire every output
        bus.rd_addr_m_i    = 5'd5;
        bus.reg_write_m_i  = 1'b1;
        bus.rs1_addr_e_i   = 5'd5;
        bus.mc_op_e_i      = 1'b1;
        bus.pc_src_e_i     = 1'b1;
        bus.result_src_e_i = 2'b01;
        bus.rd_addr_e_i    = 5'd3;
        bus.rs1_addr_d_i   = 5'd3;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 13'b00_00_000_000_000);
        clr();
        rst_n = 1'b1;
        chk("after_reset", 13'b00_00_000_000_000);

        // Forwarding
        @(negedge clk); clr();
        bus.rd_addr_m_i = 5'd5; bus.reg_write_m_i = 1'b1; bus.rs1_addr_e_i = 5'd5;
        chk("fwd_a_mem", 13'b10_00_000_000_000);
        @(negedge clk);
        bus.reg_write_m_i = 1'b0; bus.rd_addr_w_i = 5'd5; bus.reg_write_w_i = 1'b1;
        chk("fwd_a_wb", 13'b01_00_000_000_000);
        @(negedge clk);
        bus.reg_write_m_i = 1'b1;
        chk("fwd_a_mem_prio", 13'b10_00_000_000_000);
        @(negedge clk);
        bus.op_a_is_rs1_e_i = 1'b0;
        chk("fwd_a_gated", 13'b00_00_000_000_000);
        @(negedge clk); clr();
        bus.rs2_addr_e_i = 5'd0; bus.rd_addr_m_i = 5'd0; bus.reg_write_m_i = 1'b1;
        chk("fwd_b_x0", 13'b00_00_000_000_000);
        @(negedge clk); clr();
        bus.rs2_addr_e_i = 5'd7; bus.rd_addr_m_i = 5'd7; bus.reg_write_m_i = 1'b1;
        chk("fwd_b_mem", 13'b00_10_000_000_000);
        @(negedge clk);
        bus.alu_src_e_i = 1'b1;
        chk("fwd_b_imm", 13'b00_00_000_000_000);
        @(negedge clk); clr();
        bus.rs2_addr_e_i = 5'd9; bus.rd_addr_w_i = 5'd9; bus.reg_write_w_i = 1'b1;
        chk("fwd_b_wb", 13'b00_01_000_000_000);

        // Load-use and redirect
        @(negedge clk); clr();
        bus.result_src_e_i = 2'b01; bus.rd_addr_e_i = 5'd6; bus.rs1_addr_d_i = 5'd6;
        chk("lw_stall_rs1", 13'b00_00_110_010_000);
        @(negedge clk); clr();
        chk("lw_bubble_next", 13'b00_00_000_000_000);
        @(negedge clk);
        bus.result_src_e_i = 2'b01; bus.rd_addr_e_i = 5'd6; bus.rs2_addr_d_i = 5'd6;
        chk("lw_stall_rs2", 13'b00_00_110_010_000);
        @(negedge clk); clr();
        bus.result_src_e_i = 2'b01; bus.rd_addr_e_i = 5'd0;
        chk("lw_x0", 13'b00_00_000_000_000);
        @(negedge clk); clr();
        bus.result_src_e_i = 2'b00; bus.rd_addr_e_i = 5'd6; bus.rs1_addr_d_i = 5'd6;
        chk("no_load", 13'b00_00_000_000_000);
        @(negedge clk);
        bus.result_src_e_i = 2'b01; bus.pc_src_e_i = 1'b1;
        chk("lw_and_redirect", 13'b00_00_000_110_000);
        @(negedge clk); clr();
        bus.pc_src_e_i = 1'b1;
        chk("redirect_only", 13'b00_00_000_110_000);

        // Multi-cycle op, done 5 cycles after start
        @(negedge clk); clr();
        bus.mc_op_e_i = 1'b1;
        chk("mc_start", 13'b00_00_111_001_100);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.result_src_e_i = 2'b01; bus.rd_addr_e_i = 5'd6; bus.rs1_addr_d_i = 5'd6;
            end else begin
                bus.result_src_e_i = 2'b00;
            end
            chk($sformatf("mc_busy_c%0d", i), 13'b00_00_111_001_010);
        end
        @(negedge clk);
        bus.mc_done_i = 1'b1;
        chk("mc_release", 13'b00_00_000_000_010);
        @(negedge clk); clr();
        chk("mc_back_idle", 13'b00_00_000_000_000);

        // Zero-latency op
        @(negedge clk);
        bus.mc_op_e_i = 1'b1; bus.mc_done_i = 1'b1;
        chk("mc_zero_lat", 13'b00_00_000_000_100);
        @(negedge clk); clr();
        chk("mc_zero_idle", 13'b00_00_000_000_000);

        // Multi-cycle op squashed by redirect: no start
        @(negedge clk);
        bus.mc_op_e_i = 1'b1; bus.pc_src_e_i = 1'b1;
        chk("mc_redirect", 13'b00_00_000_110_000);
        @(negedge clk); clr();
        chk("mc_redirect_idle", 13'b00_00_000_000_000);

        // Timeout with MC_TIMEOUT=8
        @(negedge clk);
        bus.mc_op_e_i = 1'b1;
        chk("to_start", 13'b00_00_111_001_100);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("to_busy_c%0d", i), 13'b00_00_111_001_010);
        end
        @(negedge clk);
        chk("to_release", 13'b00_00_000_000_010);
        @(negedge clk); clr();
        chk("to_error_set", 13'b00_00_000_000_001);
        @(negedge clk);
        bus.pc_src_e_i = 1'b1;
        chk("to_error_sticky", 13'b00_00_000_110_001);

        // Reset mid-BUSY
        @(negedge clk); clr();
        bus.mc_op_e_i = 1'b1;
        chk("rst_start", 13'b00_00_111_001_101);
        @(negedge clk);
        chk("rst_busy", 13'b00_00_111_001_011);
        rst_n = 1'b0;
        chk("rst_async", 13'b00_00_000_000_000);
        @(negedge clk); clr();
        rst_n = 1'b1;
        chk("rst_released", 13'b00_00_000_000_000);
        @(negedge clk);
        chk("rst_no_repulse", 13'b00_00_000_000_000);

        // Back-to-back ops after reset
        @(negedge clk);
        bus.mc_op_e_i = 1'b1;
        chk("b2b_start1", 13'b00_00_111_001_100);
        @(negedge clk);
        bus.mc_done_i = 1'b1;
        chk("b2b_release1", 13'b00_00_000_000_010);
        @(negedge clk);
        bus.mc_done_i = 1'b0;
        chk("b2b_start2", 13'b00_00_111_001_100);
        @(negedge clk);
        bus.mc_done_i = 1'b1;
        chk("b2b_release2", 13'b00_00_000_000_010);
        @(negedge clk); clr();
        chk("b2b_idle", 13'b00_00_000_000_000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
